// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op encodings, funct codes, EX state and EX/MEM bank.
package mips_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;

  typedef enum logic [1:0] {IDLE, MUL, FIX} ex_state_t;

  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        memto_reg;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] branch_target;
    logic [4:0]  dest_reg;
  } ex_mem_t;

endpackage

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one iteration per cycle on magnitudes, sign fixed at the end.
module mult_seq
  import mips_pkg::*;
#(
  parameter int unsigned MulIter = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CntW = $clog2(MulIter);
  localparam logic [CntW-1:0] LastCnt = CntW'(MulIter - 1);

  ex_state_t      state_q;
  logic [63:0]    acc_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]    mcand_q, mplier_q, hi_q, lo_q;
  logic           neg_q;

  logic [31:0] abs_a, abs_b;
  logic [32:0] sum;
  logic [63:0] prod;

  always_comb begin
    abs_a = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
    abs_b = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;
    // 33-bit add keeps the carry that the right shift moves into bit 63
    sum   = mplier_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, mcand_q}) : {1'b0, acc_q[63:32]};
    prod  = neg_q ? (64'd0 - acc_q) : acc_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q  <= abs_a;
            mplier_q <= abs_b;
            neg_q    <= signed_i & (a_i[31] ^ b_i[31]);
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL;
          end
        end
        MUL: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q    <= {sum, acc_q[31:1]};
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush_i) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand mux, ALU, branch target and the registered EX/MEM bank.
module ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned MUL_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        branch,
  input  logic        jump,
  input  logic        AluSrc,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic [1:0]  AluOp,
  input  logic [31:0] npc,
  input  logic [31:0] readdata1,
  input  logic [31:0] readdata2,
  input  logic [31:0] sigext,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        valid_out,
  output logic        branch_out,
  output logic        jump_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        zero_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [31:0] branch_target_out,
  output logic [4:0]  dest_reg_out
);

  ex_mem_t     ex_mem_d, ex_mem_q;
  logic [31:0] op_b, alu_res, hi, lo;
  logic [5:0]  funct;
  logic        accept, is_mul, busy;

  assign op_b   = AluSrc ? sigext : readdata2;
  assign funct  = sigext[5:0];
  assign stall  = busy;
  assign accept = in_valid && !busy && !flush;
  assign is_mul = (AluOp == ALU_RTYPE) && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU));

  mult_seq #(
    .MulIter(MUL_ITER)
  ) u_mult (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (accept && is_mul),
    .signed_i(funct == FUNCT_MULT),
    .a_i     (readdata1),
    .b_i     (op_b),
    .flush_i (flush),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always_comb begin
    alu_res = '0;
    unique case (AluOp)
      ALU_ADD: alu_res = readdata1 + op_b;
      ALU_SUB: alu_res = readdata1 - op_b;
      ALU_OR:  alu_res = readdata1 | op_b;
      default: begin
        case (funct)
          FUNCT_ADD:  alu_res = readdata1 + op_b;
          FUNCT_SUB:  alu_res = readdata1 - op_b;
          FUNCT_AND:  alu_res = readdata1 & op_b;
          FUNCT_OR:   alu_res = readdata1 | op_b;
          FUNCT_SLT:  alu_res = {31'd0, $signed(readdata1) < $signed(op_b)};
          FUNCT_MFHI: alu_res = hi;
          FUNCT_MFLO: alu_res = lo;
          default:    alu_res = '0;
        endcase
      end
    endcase
  end

  // Anything not accepted (bubble, stall, flush) registers as an all-zero bubble
  always_comb begin
    ex_mem_d = '0;
    if (accept) begin
      ex_mem_d.valid         = 1'b1;
      ex_mem_d.branch        = branch;
      ex_mem_d.jump          = jump;
      ex_mem_d.mem_read      = MemRead;
      ex_mem_d.mem_write     = MemWrite;
      ex_mem_d.reg_write     = RegWrite && !is_mul;
      ex_mem_d.memto_reg     = MemtoReg;
      ex_mem_d.zero          = (alu_res == 32'd0);
      ex_mem_d.alu_result    = alu_res;
      ex_mem_d.store_data    = readdata2;
      ex_mem_d.branch_target = npc + (sigext << 2);
      ex_mem_d.dest_reg      = RegDst ? rd : rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign valid_out         = ex_mem_q.valid;
  assign branch_out        = ex_mem_q.branch;
  assign jump_out          = ex_mem_q.jump;
  assign MemRead_out       = ex_mem_q.mem_read;
  assign MemWrite_out      = ex_mem_q.mem_write;
  assign RegWrite_out      = ex_mem_q.reg_write;
  assign MemtoReg_out      = ex_mem_q.memto_reg;
  assign zero_out          = ex_mem_q.zero;
  assign alu_result_out    = ex_mem_q.alu_result;
  assign store_data_out    = ex_mem_q.store_data;
  assign branch_target_out = ex_mem_q.branch_target;
  assign dest_reg_out      = ex_mem_q.dest_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: randomized and directed instructions against a behavioural model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic        branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
  logic [1:0]  AluOp;
  logic [31:0] npc, readdata1, readdata2, sigext;
  logic [4:0]  rt, rd;
  logic        stall, valid_out, branch_out, jump_out, MemRead_out, MemWrite_out;
  logic        RegWrite_out, MemtoReg_out, zero_out;
  logic [31:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]  dest_reg_out;

  ex_stage #(.MUL_ITER(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .branch(branch), .jump(jump), .AluSrc(AluSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .AluOp(AluOp), .npc(npc), .readdata1(readdata1), .readdata2(readdata2),
    .sigext(sigext), .rt(rt), .rd(rd), .stall(stall), .valid_out(valid_out),
    .branch_out(branch_out), .jump_out(jump_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .zero_out(zero_out), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .branch_target_out(branch_target_out),
    .dest_reg_out(dest_reg_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        br, jp, mr, mw, rw, mtr, zero;
    logic [31:0] alu, store, target;
    logic [4:0]  dest;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] ref_alu(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                          logic [5:0] fn);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: begin
        case (fn)
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  // Drive one instruction, wait out any stall, push its expected EX/MEM image.
  task automatic issue(input logic [1:0] op, input logic src, input logic rw,
                       input logic rdst, input logic br, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] sx, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] opb;
    logic [63:0] p;
    int          guard;
    AluOp = op; AluSrc = src; RegWrite = rw; RegDst = rdst; branch = br;
    jump = $urandom_range(0, 1); MemRead = $urandom_range(0, 1);
    MemWrite = $urandom_range(0, 1); MemtoReg = $urandom_range(0, 1);
    readdata1 = a; readdata2 = b; sigext = sx; npc = pc;
    rt = 5'($urandom); rd = 5'($urandom);
    in_valid = 1'b1; flush = 1'b0;
    guard = 0;
    while (stall && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) check("issue_stall_timeout", 128'(stall), 128'(0));
    opb = src ? sx : b;
    e.br = br; e.jp = jump; e.mr = MemRead; e.mw = MemWrite; e.mtr = MemtoReg;
    e.alu = ref_alu(op, a, opb, sx[5:0]);
    e.zero = (e.alu == 32'd0);
    e.store = b;
    e.target = pc + {sx[29:0], 2'b00};
    e.dest = rdst ? rd : rt;
    e.rw = rw;
    if (op == 2'b10 && (sx[5:0] == 6'h18 || sx[5:0] == 6'h19)) begin
      e.rw = 1'b0;
      if (sx[5:0] == 6'h18) p = 64'($signed(a)) * 64'($signed(opb));
      else                  p = {32'd0, a} * {32'd0, opb};
      m_hi = p[63:32];
      m_lo = p[31:0];
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every registered instruction is popped and compared in order.
  initial begin
    exp_t e, act;
    forever begin
      @(negedge clk);
      if (valid_out) begin
        act = {branch_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out,
               zero_out, alu_result_out, store_data_out, branch_target_out, dest_reg_out};
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'(act), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("exmem_bank", 128'(act), 128'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] all_outs();
    return {stall, valid_out, branch_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out,
            MemtoReg_out, zero_out, alu_result_out, store_data_out, branch_target_out,
            dest_reg_out};
  endfunction

  localparam logic [5:0] Functs[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h19,
                                       6'h10, 6'h12};

  initial begin
    logic [31:0] sv_hi, sv_lo, sx;
    logic [5:0]  fn;
    int          cnt;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    {branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg} = '0;
    AluOp = 2'b00; npc = '0; readdata1 = '0; readdata2 = '0; sigext = '0; rt = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 128'(0));
    reset = 1'b0;

    // R-type add overflow wraps, 1-cycle latency
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 32'h0000_0020, 32'h40);
    check("add_latency_valid", 128'(valid_out), 128'(1));
    check("add_result", 128'(alu_result_out), 128'(32'h80000000));
    check("add_zero", 128'(zero_out), 128'(0));
    check("add_dest_rd", 128'(dest_reg_out), 128'(rd));

    // beq compare with negative offset
    issue(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 32'hFFFFFFFF, 32'h100);
    check("beq_zero", 128'(zero_out), 128'(1));
    check("beq_target", 128'(branch_target_out), 128'(32'hFC));

    // mult -3 x 7 followed by mfhi/mflo
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, 32'h0000_0018, 32'h0);
    check("mult_regwrite", 128'(RegWrite_out), 128'(0));
    cnt = 0;
    while (stall && cnt < 100) begin
      cnt++; @(posedge clk); #1;
    end
    check("mult_stall_cycles", 128'(cnt), 128'(33));
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 32'h0);
    check("mfhi_signed", 128'(alu_result_out), 128'(32'hFFFFFFFF));
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0012, 32'h0);
    check("mflo_signed", 128'(alu_result_out), 128'(32'hFFFFFFEB));

    // multu; mfhi is issued immediately and held behind the stall
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h0000_0019, 32'h0);
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 32'h0);
    check("mfhi_unsigned", 128'(alu_result_out), 128'(32'd1));
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0012, 32'h0);
    check("mflo_unsigned", 128'(alu_result_out), 128'(32'hFFFFFFFE));

    // flush 10 cycles into a multiply leaves HI/LO untouched
    sv_hi = m_hi; sv_lo = m_lo;
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1234, 32'd5678, 32'h0000_0019, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall_drop", 128'(stall), 128'(0));
    m_hi = sv_hi; m_lo = sv_lo;
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 32'h0);
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0012, 32'h0);

    // flush wins over in_valid
    AluOp = 2'b00; RegWrite = 1'b1; readdata1 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_bubble_valid", 128'(valid_out), 128'(0));
    check("flush_bubble_regwrite", 128'(RegWrite_out), 128'(0));

    // randomized mix with idle gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      sx = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        fn = ($urandom_range(0, 9) == 9) ? 6'($urandom) : Functs[$urandom_range(0, 8)];
        if ((fn == 6'h18 || fn == 6'h19) && $urandom_range(0, 3) != 0) fn = 6'h20;
        sx = {sx[31:6], fn};
        issue(2'b10, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), $urandom,
              $urandom, sx, $urandom);
      end else begin
        issue(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom, sx, $urandom);
      end
    end

    // reset in the middle of a multiply
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0000_0018, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midmul_reset_outputs", all_outs(), 128'(0));
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    issue(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'd40, 32'd0, 32'd2, 32'h8);
    check("post_reset_add", 128'(alu_result_out), 128'(32'd42));
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 32'h0);
    check("post_reset_hi", 128'(alu_result_out), 128'(0));
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0012, 32'h0);
    check("post_reset_lo", 128'(alu_result_out), 128'(0));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
